// File: rtl/ag32gbd_bram_arbiter_pkg.sv
// Shared constants, requester ids and FSM states for the camera BRAM arbiter.
package ag32gbd_bram_pkg;

   localparam int ADDR_W        = 10;
   localparam int DATA_W        = 8;
   localparam int REG_COUNT     = 48;
   localparam int CAM_BURST_MAX = 4;
   localparam int BURST_W       = $clog2(CAM_BURST_MAX + 1);

   localparam logic [ADDR_W-1:0] BUF_A_BASE = 10'h000;
   localparam logic [ADDR_W-1:0] BUF_B_BASE = 10'h100;
   localparam logic [ADDR_W-1:0] REG_BASE   = 10'h200;

   typedef enum logic [1:0] {
      REQ_CAM,
      REQ_BUFRD,
      REQ_REGWR,
      REQ_REGRD
   } req_id_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_RD_WAIT
   } state_t;

   // True when a register index falls inside the compare-matrix window.
   function automatic logic reg_idx_ok(input logic [5:0] idx);
      return idx < 6'(REG_COUNT);
   endfunction

   // BRAM address of a register index.
   function automatic logic [ADDR_W-1:0] reg_addr(input logic [5:0] idx);
      return REG_BASE + {4'b0000, idx};
   endfunction

endpackage

// File: rtl/ag32gbd_bram_arbiter_if.sv
// Requester handshakes, flip control and BRAM port bundled for the arbiter.
interface ag32gbd_bram_arbiter_if;
   import ag32gbd_bram_pkg::*;

   logic              cam_wr_req;
   logic [7:0]        cam_wr_off;
   logic [DATA_W-1:0] cam_wr_data;
   logic              cam_wr_ack;

   logic              buf_rd_req;
   logic [7:0]        buf_rd_off;
   logic              buf_rd_ack;
   logic [DATA_W-1:0] buf_rd_data;

   logic              reg_wr_req;
   logic [5:0]        reg_wr_idx;
   logic [DATA_W-1:0] reg_wr_data;
   logic              reg_wr_ack;

   logic              reg_rd_req;
   logic [5:0]        reg_rd_idx;
   logic              reg_rd_ack;
   logic [DATA_W-1:0] reg_rd_data;

   logic              reg_err;

   logic              flip_req;
   logic              flip_done;
   logic              front_sel;

   logic              bram_en;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_wdata;
   logic [DATA_W-1:0] bram_rdata;

   modport slave (
      input  cam_wr_req, cam_wr_off, cam_wr_data,
      input  buf_rd_req, buf_rd_off,
      input  reg_wr_req, reg_wr_idx, reg_wr_data,
      input  reg_rd_req, reg_rd_idx,
      input  flip_req, bram_rdata,
      output cam_wr_ack, buf_rd_ack, buf_rd_data,
      output reg_wr_ack, reg_rd_ack, reg_rd_data, reg_err,
      output flip_done, front_sel,
      output bram_en, bram_we, bram_addr, bram_wdata
   );

   modport master (
      output cam_wr_req, cam_wr_off, cam_wr_data,
      output buf_rd_req, buf_rd_off,
      output reg_wr_req, reg_wr_idx, reg_wr_data,
      output reg_rd_req, reg_rd_idx,
      output flip_req, bram_rdata,
      input  cam_wr_ack, buf_rd_ack, buf_rd_data,
      input  reg_wr_ack, reg_rd_ack, reg_rd_data, reg_err,
      input  flip_done, front_sel,
      input  bram_en, bram_we, bram_addr, bram_wdata
   );

endinterface

// File: rtl/ag32gbd_bram_arbiter_rr.sv
// Three-way round robin among buffer read (0), register write (1), register read (2).
module ag32gbd_rr_arbiter
   import ag32gbd_bram_pkg::*;
(
   input  logic       sys_clock,
   input  logic       sys_reset,
   input  logic [2:0] req,
   input  logic       advance,
   output logic       valid,
   output logic [1:0] grant
);

   logic [1:0] ptr;
   logic [1:0] cand1;
   logic [1:0] cand2;

   function automatic logic [1:0] next3(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   // Search from the pointer onwards for the first active requester.
   always_comb begin
      cand1 = next3(ptr);
      cand2 = next3(cand1);
      valid = 1'b1;
      grant = ptr;
      if (req[ptr]) begin
         grant = ptr;
      end else if (req[cand1]) begin
         grant = cand1;
      end else if (req[cand2]) begin
         grant = cand2;
      end else begin
         valid = 1'b0;
      end
   end

   // Pointer moves past the winner only when its grant is actually taken.
   always_ff @(posedge sys_clock) begin
      if (sys_reset) begin
         ptr <= 2'd0;
      end else if (advance && valid) begin
         ptr <= next3(grant);
      end
   end

endmodule

// File: rtl/ag32gbd_bram_arbiter.sv
// Shares the single-port camera BRAM among camera writes, buffer reads and
// register accesses, and owns the ping-pong front/back buffer selection.
module ag32gbd_bram_arbiter
   import ag32gbd_bram_pkg::*;
(
   input  logic                    sys_clock,
   input  logic                    sys_reset,
   ag32gbd_bram_arbiter_if.slave   bus
);

   state_t               state;
   req_id_t              cur_id;
   logic                 cur_bad;
   logic                 flip_pend;
   logic [BURST_W-1:0]   burst_cnt;

   logic                 others;
   logic                 force_noncam;
   logic                 grant_cam;
   logic                 rr_advance;
   logic                 rr_valid;
   logic [1:0]           rr_grant;
   req_id_t              rr_id;
   logic [ADDR_W-1:0]    cam_addr;
   logic [ADDR_W-1:0]    buf_addr;

   // Camera priority with a forced non-camera slot once the burst limit is hit.
   always_comb begin
      others       = bus.buf_rd_req | bus.reg_wr_req | bus.reg_rd_req;
      force_noncam = others && (burst_cnt == BURST_W'(CAM_BURST_MAX));
      grant_cam    = bus.cam_wr_req && !force_noncam;
      rr_advance   = (state == ST_IDLE) && !flip_pend && !grant_cam;
      rr_id        = req_id_t'(rr_grant + 2'd1);
      cam_addr     = (bus.front_sel ? BUF_A_BASE : BUF_B_BASE) | {2'b00, bus.cam_wr_off};
      buf_addr     = (bus.front_sel ? BUF_B_BASE : BUF_A_BASE) | {2'b00, bus.buf_rd_off};
   end

   ag32gbd_rr_arbiter u_rr (
      .sys_clock (sys_clock),
      .sys_reset (sys_reset),
      .req       ({bus.reg_rd_req, bus.reg_wr_req, bus.buf_rd_req}),
      .advance   (rr_advance),
      .valid     (rr_valid),
      .grant     (rr_grant)
   );

   // Transaction FSM: grant and BRAM drive in IDLE, write ack in ISSUE, read capture in RD_WAIT.
   always_ff @(posedge sys_clock) begin
      if (sys_reset) begin
         state           <= ST_IDLE;
         cur_id          <= REQ_CAM;
         cur_bad         <= 1'b0;
         flip_pend       <= 1'b0;
         burst_cnt       <= '0;
         bus.front_sel   <= 1'b0;
         bus.flip_done   <= 1'b0;
         bus.cam_wr_ack  <= 1'b0;
         bus.buf_rd_ack  <= 1'b0;
         bus.reg_wr_ack  <= 1'b0;
         bus.reg_rd_ack  <= 1'b0;
         bus.reg_err     <= 1'b0;
         bus.buf_rd_data <= '0;
         bus.reg_rd_data <= '0;
         bus.bram_en     <= 1'b0;
         bus.bram_we     <= 1'b0;
         bus.bram_addr   <= '0;
         bus.bram_wdata  <= '0;
      end else begin
         bus.flip_done  <= 1'b0;
         bus.cam_wr_ack <= 1'b0;
         bus.buf_rd_ack <= 1'b0;
         bus.reg_wr_ack <= 1'b0;
         bus.reg_rd_ack <= 1'b0;
         bus.reg_err    <= 1'b0;
         bus.bram_en    <= 1'b0;
         bus.bram_we    <= 1'b0;
         if (bus.flip_req) begin
            flip_pend <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (flip_pend) begin
                  bus.front_sel <= ~bus.front_sel;
                  bus.flip_done <= 1'b1;
                  flip_pend     <= 1'b0;
               end else if (grant_cam) begin
                  state          <= ST_ISSUE;
                  cur_id         <= REQ_CAM;
                  cur_bad        <= 1'b0;
                  bus.bram_en    <= 1'b1;
                  bus.bram_we    <= 1'b1;
                  bus.bram_addr  <= cam_addr;
                  bus.bram_wdata <= bus.cam_wr_data;
                  burst_cnt      <= others ? burst_cnt + BURST_W'(1) : '0;
               end else if (rr_valid) begin
                  state     <= ST_ISSUE;
                  cur_id    <= rr_id;
                  burst_cnt <= '0;
                  case (rr_id)
                     REQ_BUFRD: begin
                        cur_bad       <= 1'b0;
                        bus.bram_en   <= 1'b1;
                        bus.bram_addr <= buf_addr;
                     end
                     REQ_REGWR: begin
                        cur_bad        <= !reg_idx_ok(bus.reg_wr_idx);
                        bus.bram_en    <= reg_idx_ok(bus.reg_wr_idx);
                        bus.bram_we    <= reg_idx_ok(bus.reg_wr_idx);
                        bus.bram_addr  <= reg_addr(bus.reg_wr_idx);
                        bus.bram_wdata <= bus.reg_wr_data;
                     end
                     default: begin
                        cur_bad       <= !reg_idx_ok(bus.reg_rd_idx);
                        bus.bram_en   <= reg_idx_ok(bus.reg_rd_idx);
                        bus.bram_addr <= reg_addr(bus.reg_rd_idx);
                     end
                  endcase
               end else if (!others) begin
                  burst_cnt <= '0;
               end
            end
            ST_ISSUE: begin
               if (cur_id == REQ_CAM) begin
                  bus.cam_wr_ack <= 1'b1;
                  state          <= ST_IDLE;
               end else if (cur_id == REQ_REGWR) begin
                  bus.reg_wr_ack <= 1'b1;
                  bus.reg_err    <= cur_bad;
                  state          <= ST_IDLE;
               end else begin
                  state <= ST_RD_WAIT;
               end
            end
            ST_RD_WAIT: begin
               if (cur_id == REQ_BUFRD) begin
                  bus.buf_rd_data <= bus.bram_rdata;
                  bus.buf_rd_ack  <= 1'b1;
               end else begin
                  bus.reg_rd_data <= cur_bad ? '0 : bus.bram_rdata;
                  bus.reg_rd_ack  <= 1'b1;
                  bus.reg_err     <= cur_bad;
               end
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ag32gbd_bram_arbiter.sv
// Directed self-checking bench for the camera BRAM arbiter with a behavioural BRAM.
module tb_ag32gbd_bram_arbiter;

   logic clk = 1'b0;
   logic sys_reset = 1'b1;
   logic mem_clear = 1'b1;
   int   total = 0;
   int   bad = 0;

   logic [7:0] mem [0:1023];

   ag32gbd_bram_arbiter_if bus();

   ag32gbd_bram_arbiter dut (
      .sys_clock (clk),
      .sys_reset (sys_reset),
      .bus       (bus)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Synchronous read-first 1024x8 BRAM with a few preloaded words.
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
         mem[10'h202] <= 8'h5A;
         mem[10'h106] <= 8'hC3;
      end else if (bus.bram_en) begin
         if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_wdata;
         bus.bram_rdata <= mem[bus.bram_addr];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.cam_wr_req  = 1'b0;
      bus.cam_wr_off  = 8'h00;
      bus.cam_wr_data = 8'h00;
      bus.buf_rd_req  = 1'b0;
      bus.buf_rd_off  = 8'h00;
      bus.reg_wr_req  = 1'b0;
      bus.reg_wr_idx  = 6'd0;
      bus.reg_wr_data = 8'h00;
      bus.reg_rd_req  = 1'b0;
      bus.reg_rd_idx  = 6'd0;
      bus.flip_req    = 1'b0;
   endtask

   task automatic test_reset();
      logic [6:0] pulses;
      clear_inputs();
      sys_reset = 1'b1;
      step();
      mem_clear = 1'b0;
      step();
      pulses = {bus.cam_wr_ack, bus.buf_rd_ack, bus.reg_wr_ack, bus.reg_rd_ack,
                bus.reg_err, bus.flip_done, bus.front_sel};
      total++;
      if (pulses !== 7'd0) begin
         bad++;
         $display("[TB] FAIL reset_flags: got %b want 0000000", pulses);
      end
      total++;
      if ({bus.bram_en, bus.bram_we} !== 2'b00) begin
         bad++;
         $display("[TB] FAIL reset_bram_ctl: got %b want 00", {bus.bram_en, bus.bram_we});
      end
      total++;
      if ({bus.bram_addr, bus.bram_wdata} !== 18'd0) begin
         bad++;
         $display("[TB] FAIL reset_bram_bus: got %h/%h want 000/00", bus.bram_addr, bus.bram_wdata);
      end
      total++;
      if ({bus.buf_rd_data, bus.reg_rd_data} !== 16'd0) begin
         bad++;
         $display("[TB] FAIL reset_rd_data: got %h/%h want 00/00", bus.buf_rd_data, bus.reg_rd_data);
      end
      sys_reset = 1'b0;
      step();
   endtask

   task automatic test_reg_access();
      bus.reg_wr_req  = 1'b1;
      bus.reg_wr_idx  = 6'd5;
      bus.reg_wr_data = 8'hA5;
      step();
      total++;
      if ({bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_wdata} !== {2'b11, 10'h205, 8'hA5}) begin
         bad++;
         $display("[TB] FAIL reg_wr_issue: got en=%b we=%b addr=%h wd=%h want 1 1 205 a5",
                  bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_wdata);
      end
      step();
      total++;
      if ({bus.reg_wr_ack, bus.reg_err} !== 2'b10) begin
         bad++;
         $display("[TB] FAIL reg_wr_ack: got ack=%b err=%b want 1 0", bus.reg_wr_ack, bus.reg_err);
      end
      bus.reg_wr_req = 1'b0;
      step();
      bus.reg_rd_req = 1'b1;
      bus.reg_rd_idx = 6'd5;
      step();
      total++;
      if ({bus.bram_en, bus.bram_we, bus.bram_addr} !== {2'b10, 10'h205}) begin
         bad++;
         $display("[TB] FAIL reg_rd_issue: got en=%b we=%b addr=%h want 1 0 205",
                  bus.bram_en, bus.bram_we, bus.bram_addr);
      end
      step();
      total++;
      if (bus.reg_rd_ack !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reg_rd_early_ack: got %b want 0", bus.reg_rd_ack);
      end
      step();
      total++;
      if ({bus.reg_rd_ack, bus.reg_err, bus.reg_rd_data} !== {2'b10, 8'hA5}) begin
         bad++;
         $display("[TB] FAIL reg_rd_ack: got ack=%b err=%b data=%h want 1 0 a5",
                  bus.reg_rd_ack, bus.reg_err, bus.reg_rd_data);
      end
      bus.reg_rd_req = 1'b0;
      step();
      total++;
      if ({bus.reg_rd_ack, bus.reg_rd_data} !== {1'b0, 8'hA5}) begin
         bad++;
         $display("[TB] FAIL reg_rd_hold: got ack=%b data=%h want 0 a5", bus.reg_rd_ack, bus.reg_rd_data);
      end
   endtask

   task automatic test_cam_flip();
      int         flips = 0;
      logic [9:0] rd_addr = 10'h3FF;
      logic [7:0] rd_data = 8'hFF;
      logic       got_ack = 1'b0;
      bus.cam_wr_req  = 1'b1;
      bus.cam_wr_off  = 8'h10;
      bus.cam_wr_data = 8'h3C;
      step();
      total++;
      if ({bus.bram_we, bus.bram_addr, bus.bram_wdata} !== {1'b1, 10'h110, 8'h3C}) begin
         bad++;
         $display("[TB] FAIL cam_wr_issue: got we=%b addr=%h wd=%h want 1 110 3c",
                  bus.bram_we, bus.bram_addr, bus.bram_wdata);
      end
      step();
      total++;
      if (bus.cam_wr_ack !== 1'b1) begin
         bad++;
         $display("[TB] FAIL cam_wr_ack: got %b want 1", bus.cam_wr_ack);
      end
      bus.cam_wr_req = 1'b0;
      bus.flip_req   = 1'b1;
      step();
      bus.flip_req   = 1'b0;
      bus.buf_rd_req = 1'b1;
      bus.buf_rd_off = 8'h10;
      for (int c = 0; c < 12 && !got_ack; c++) begin
         step();
         if (bus.flip_done === 1'b1) flips++;
         if (bus.bram_en === 1'b1) rd_addr = bus.bram_addr;
         if (bus.buf_rd_ack === 1'b1) begin
            got_ack = 1'b1;
            rd_data = bus.buf_rd_data;
         end
      end
      bus.buf_rd_req = 1'b0;
      repeat (3) begin
         step();
         if (bus.flip_done === 1'b1) flips++;
      end
      total++;
      if (got_ack !== 1'b1) begin
         bad++;
         $display("[TB] FAIL flip_rd_timeout: got ack=%b want 1", got_ack);
      end
      total++;
      if ({rd_addr, rd_data} !== {10'h110, 8'h3C}) begin
         bad++;
         $display("[TB] FAIL flip_rd: got addr=%h data=%h want 110 3c", rd_addr, rd_data);
      end
      total++;
      if (flips != 1 || bus.front_sel !== 1'b1) begin
         bad++;
         $display("[TB] FAIL flip_once: got flips=%0d front=%b want 1 1", flips, bus.front_sel);
      end
   endtask

   task automatic test_burst();
      int exp_seq [15] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 3};
      int got_seq [15];
      int n = 0;
      for (int i = 0; i < 15; i++) got_seq[i] = -1;
      sys_reset = 1'b1;
      step();
      sys_reset = 1'b0;
      bus.cam_wr_req  = 1'b1;
      bus.cam_wr_off  = 8'h20;
      bus.cam_wr_data = 8'h11;
      bus.buf_rd_req  = 1'b1;
      bus.buf_rd_off  = 8'h00;
      bus.reg_wr_req  = 1'b1;
      bus.reg_wr_idx  = 6'd1;
      bus.reg_wr_data = 8'h22;
      bus.reg_rd_req  = 1'b1;
      bus.reg_rd_idx  = 6'd2;
      for (int c = 0; c < 120 && n < 15; c++) begin
         step();
         if (bus.cam_wr_ack === 1'b1) begin got_seq[n] = 0; n++; end
         else if (bus.buf_rd_ack === 1'b1) begin got_seq[n] = 1; n++; end
         else if (bus.reg_wr_ack === 1'b1) begin got_seq[n] = 2; n++; end
         else if (bus.reg_rd_ack === 1'b1) begin got_seq[n] = 3; n++; end
      end
      clear_inputs();
      repeat (4) step();
      total++;
      if (n != 15) begin
         bad++;
         $display("[TB] FAIL burst_count: got %0d grants want 15", n);
      end
      for (int i = 0; i < 15; i++) begin
         total++;
         if (got_seq[i] != exp_seq[i]) begin
            bad++;
            $display("[TB] FAIL burst_grant_%0d: got %0d want %0d", i, got_seq[i], exp_seq[i]);
         end
      end
      total++;
      if (bus.reg_rd_data !== 8'h5A) begin
         bad++;
         $display("[TB] FAIL burst_reg_rd_data: got %h want 5a", bus.reg_rd_data);
      end
   endtask

   task automatic test_reg_err();
      logic en_seen = 1'b0;
      bus.reg_rd_req = 1'b1;
      bus.reg_rd_idx = 6'd50;
      step();
      en_seen |= bus.bram_en;
      step();
      en_seen |= bus.bram_en;
      total++;
      if (bus.reg_rd_ack !== 1'b0) begin
         bad++;
         $display("[TB] FAIL err_rd_early_ack: got %b want 0", bus.reg_rd_ack);
      end
      step();
      total++;
      if ({bus.reg_rd_ack, bus.reg_err, bus.reg_rd_data} !== {2'b11, 8'h00}) begin
         bad++;
         $display("[TB] FAIL err_rd_ack: got ack=%b err=%b data=%h want 1 1 00",
                  bus.reg_rd_ack, bus.reg_err, bus.reg_rd_data);
      end
      bus.reg_rd_req  = 1'b0;
      bus.reg_wr_req  = 1'b1;
      bus.reg_wr_idx  = 6'd48;
      bus.reg_wr_data = 8'h77;
      step();
      en_seen |= bus.bram_en | bus.bram_we;
      step();
      total++;
      if ({bus.reg_wr_ack, bus.reg_err} !== 2'b11) begin
         bad++;
         $display("[TB] FAIL err_wr_ack: got ack=%b err=%b want 1 1", bus.reg_wr_ack, bus.reg_err);
      end
      bus.reg_wr_req = 1'b0;
      step();
      total++;
      if (en_seen !== 1'b0 || mem[10'h230] !== 8'h00 || bus.reg_err !== 1'b0) begin
         bad++;
         $display("[TB] FAIL err_no_access: got en_seen=%b mem230=%h err=%b want 0 00 0",
                  en_seen, mem[10'h230], bus.reg_err);
      end
   endtask

   task automatic test_flip_in_rdwait();
      int flips = 0;
      bus.buf_rd_req = 1'b1;
      bus.buf_rd_off = 8'h05;
      step();
      total++;
      if ({bus.bram_en, bus.bram_addr} !== {1'b1, 10'h005}) begin
         bad++;
         $display("[TB] FAIL fw_first_addr: got en=%b addr=%h want 1 005", bus.bram_en, bus.bram_addr);
      end
      bus.flip_req = 1'b1;
      step();
      step();
      if (bus.flip_done === 1'b1) flips++;
      total++;
      if ({bus.buf_rd_ack, bus.front_sel} !== 2'b10) begin
         bad++;
         $display("[TB] FAIL fw_first_ack: got ack=%b front=%b want 1 0", bus.buf_rd_ack, bus.front_sel);
      end
      bus.flip_req   = 1'b0;
      bus.buf_rd_off = 8'h06;
      step();
      if (bus.flip_done === 1'b1) flips++;
      total++;
      if ({bus.flip_done, bus.front_sel, bus.bram_en} !== 3'b110) begin
         bad++;
         $display("[TB] FAIL fw_flip_slot: got done=%b front=%b en=%b want 1 1 0",
                  bus.flip_done, bus.front_sel, bus.bram_en);
      end
      step();
      if (bus.flip_done === 1'b1) flips++;
      total++;
      if ({bus.bram_en, bus.bram_addr} !== {1'b1, 10'h106}) begin
         bad++;
         $display("[TB] FAIL fw_delayed_grant: got en=%b addr=%h want 1 106", bus.bram_en, bus.bram_addr);
      end
      step();
      if (bus.flip_done === 1'b1) flips++;
      step();
      if (bus.flip_done === 1'b1) flips++;
      total++;
      if ({bus.buf_rd_ack, bus.buf_rd_data} !== {1'b1, 8'hC3}) begin
         bad++;
         $display("[TB] FAIL fw_second_ack: got ack=%b data=%h want 1 c3", bus.buf_rd_ack, bus.buf_rd_data);
      end
      bus.buf_rd_req = 1'b0;
      repeat (2) begin
         step();
         if (bus.flip_done === 1'b1) flips++;
      end
      total++;
      if (flips != 1) begin
         bad++;
         $display("[TB] FAIL fw_flip_count: got %0d want 1", flips);
      end
   endtask

   task automatic test_reset_rdwait();
      int acks = 0;
      bus.buf_rd_req = 1'b1;
      bus.buf_rd_off = 8'h00;
      step();
      step();
      sys_reset = 1'b1;
      step();
      total++;
      if ({bus.buf_rd_ack, bus.front_sel, bus.bram_en, bus.buf_rd_data} !== 11'd0) begin
         bad++;
         $display("[TB] FAIL rst_rdwait: got ack=%b front=%b en=%b data=%h want 0 0 0 00",
                  bus.buf_rd_ack, bus.front_sel, bus.bram_en, bus.buf_rd_data);
      end
      sys_reset      = 1'b0;
      bus.buf_rd_req = 1'b0;
      repeat (4) begin
         step();
         if (bus.buf_rd_ack === 1'b1) acks++;
      end
      total++;
      if (acks != 0) begin
         bad++;
         $display("[TB] FAIL rst_no_ack: got %0d acks want 0", acks);
      end
   endtask

   // Scenario sequence.
   initial begin
      test_reset();
      test_reg_access();
      test_cam_flip();
      test_burst();
      test_reg_err();
      test_flip_in_rdwait();
      test_reset_rdwait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ag32gbd_bram_arbiter.md
Name: ag32gbd_bram_arbiter

Overview:
Sequences the single-port 1024x8 camera block RAM and shares it among four requesters: sensor buffer writer, cartridge-RAM buffer reader, register-file writer and register-file reader. It maps buffer offsets onto the ping-pong image buffers A/B (0x000-0x0FF / 0x100-0x1FF) and register indices onto the compare-matrix window at 0x200. It owns the front/back buffer selection and applies flip requests only between BRAM transactions.

Parameters:
ADDR_W, 10, BRAM address width
DATA_W, 8, BRAM data width
REG_BASE, 10'h200, BRAM address of register index 0
REG_COUNT, 48, number of valid register indices (0..47)
CAM_BURST_MAX, 4, maximum consecutive camera grants while another requester is pending

Ports:
sys_clock  in  1  sole clock
sys_reset  in  1  synchronous, active-high reset
cam_wr_req  in  1  camera buffer write request, level, held until ack
cam_wr_off  in  8  offset into back buffer
cam_wr_data  in  8  write data
cam_wr_ack  out  1  one-cycle pulse, write performed
buf_rd_req  in  1  buffer read request, level
buf_rd_off  in  8  offset into front buffer
buf_rd_ack  out  1  one-cycle pulse, buf_rd_data valid
buf_rd_data  out  8  read data, held until next buf_rd_ack
reg_wr_req / reg_rd_req  in  1 each  register write/read request, level
reg_wr_idx / reg_rd_idx  in  6 each  register index
reg_wr_data  in  8  register write data
reg_wr_ack / reg_rd_ack  out  1 each  one-cycle completion pulses
reg_rd_data  out  8  read data, held until next reg_rd_ack
reg_err  out  1  one-cycle pulse with ack when index >= REG_COUNT
flip_req  in  1  request to swap front/back buffers
flip_done  out  1  one-cycle pulse when swap applied
front_sel  out  1  0: A is front (read), B is back (written); 1: swapped
bram_en  out  1  BRAM port enable
bram_we  out  1  BRAM write enable
bram_addr  out  10  BRAM address
bram_wdata  out  8  BRAM write data
bram_rdata  in  8  BRAM read data, valid one cycle after en with we=0

Behaviour:
- Reset: all acks, reg_err, flip_done, bram_en, bram_we = 0. bram_addr, bram_wdata, buf_rd_data, reg_rd_data = 0. front_sel = 0. flip pending cleared, burst counter = 0, RR pointer = buf_rd. FSM = IDLE. A reset mid-transaction aborts the transaction; no ack is issued for it.
- FSM states: IDLE, ISSUE, RD_WAIT.
- IDLE: if flip pending, toggle front_sel, pulse flip_done, clear pending; no grant that cycle. Otherwise arbitrate and latch winner, address and data; go to ISSUE.
- ISSUE: drive bram_en=1; bram_we=1 for writes. Writes: ack this cycle, go to IDLE. Reads: go to RD_WAIT.
- RD_WAIT: capture bram_rdata into the requester's data register, pulse its ack, go to IDLE.
- Latency from request sampled in IDLE at cycle t: write ack at t+1; read ack and data at t+2. Issue rate is one write per 2 cycles and one read per 3 cycles. A requester may keep req high after ack with new operands for back-to-back transfers.
- Address map:
  - cam write: {1'b0, ~front_sel, off}.
  - buf read: {1'b0, front_sel, off}.
  - reg: REG_BASE + idx.
- Invalid register index (idx >= 48): no BRAM access. ISSUE holds bram_en=0. Write ack pulses with reg_err at t+1. Read ack pulses with reg_err at t+2 and reg_rd_data = 0x00.
- Arbitration: cam_wr has priority. Burst counter increments per cam grant while any other req is high and resets when a non-cam grant occurs or no other req is high. At CAM_BURST_MAX, one non-cam grant is forced.
- Non-cam requesters use 3-way round robin in order buf_rd -> reg_wr -> reg_rd. The pointer moves to the requester after the granted one.
- flip_req is latched. Further flip_req while pending coalesce, giving a single toggle. flip_req arriving while a transaction is in flight is applied at the next IDLE. front_sel is sampled at grant, so an in-flight access uses the old mapping.
- Simultaneous flip pending and requests in IDLE: the flip wins and the grant is delayed one cycle.

Decomposition:
- Package ag32gbd_bram_pkg: address constants (BUF_A_BASE, BUF_B_BASE, REG_BASE, REG_COUNT), requester-id enum (REQ_CAM, REQ_BUFRD, REQ_REGWR, REQ_REGRD), FSM state enum.
- Sub-module ag32gbd_rr_arbiter: 3-input round-robin with registered pointer and an advance input.

Test Plan:
- Reset then reg_wr idx=5 data=0xA5 -> bram_addr=0x205, we=1 at t+1, reg_wr_ack t+1. reg_rd idx=5 -> reg_rd_ack t+2, data=0xA5.
- front_sel=0, cam_wr off=0x10 data=0x3C -> addr 0x110. flip_req, then buf_rd off=0x10 -> addr 0x110, data 0x3C, flip_done once.
- cam_wr_req held high continuously with buf_rd_req, reg_wr_req, reg_rd_req all high -> grant pattern 4 cam, buf_rd, 4 cam, reg_wr, 4 cam, reg_rd.
- reg_rd idx=50 -> no bram_en, reg_rd_ack and reg_err at t+2, reg_rd_data=0x00. reg_wr idx=48 -> ack and err at t+1, no write.
- Two flip_req pulses while a read is in RD_WAIT -> single toggle at the next IDLE, one flip_done, grant delayed one cycle.
- sys_reset asserted in RD_WAIT -> no buf_rd_ack, outputs return to reset values next cycle, front_sel=0.
